// File: rtl/std_reg_arbiter.sv
// Storage register shared by N requesters: a round-robin arbiter picks one writer
// per two-cycle slot, latches its payload, commits it, and returns a ready pulse.
module std_reg_arbiter #(
  parameter int               width     = 32,
  parameter logic [width-1:0] reset_val = '0,
  parameter int               N         = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_valid,
  input  logic [N*width-1:0]   req_data,
  output logic [N-1:0]         req_ready,
  output logic [width-1:0]     out,
  output logic                 busy,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, next_state;
  logic [GW-1:0]    rr_ptr;
  logic [GW-1:0]    winner;
  logic [GW:0]      scan_sum;
  logic [GW-1:0]    scan_idx;
  logic [width-1:0] data_p0;
  logic [width-1:0] reg_q;

  assign out = reg_q;

  // Scan from the highest offset down so the first set bit at or after rr_ptr is the last one written.
  always_comb begin
    winner   = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr} + (GW + 1)'(k);
      if (scan_sum >= (GW + 1)'(N)) scan_sum = scan_sum - (GW + 1)'(N);
      scan_idx = scan_sum[GW-1:0];
      if (req_valid[scan_idx]) winner = scan_idx;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (|req_valid) next_state = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        // A reset landing on the commit cycle aborts the write, so no pulse either.
        if (!reset) req_ready[grant] = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Stage p0: grant edge captures winner index and payload
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
      reg_q  <= reset_val;
    end else begin
      state <= next_state;
      if (state == IDLE && |req_valid) grant <= winner;
      // Stage p1: commit edge writes the register and moves the pointer past the winner
      if (state == BUSY) begin
        reg_q <= data_p0;
        if (grant == GW'(N - 1)) rr_ptr <= '0;
        else                     rr_ptr <= grant + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && |req_valid) data_p0 <= req_data[int'(winner)*width +: width];
  end

endmodule

// File: doc/std_reg_arbiter.md
Name: std_reg_arbiter

Overview:
- Shares one width-bit storage register between N requesters, each with a valid/ready write handshake.
- Round-robin arbitration grants one requester at a time. The granted data is committed into the register, and the winner gets a one-cycle ready pulse.
- Used wherever the compiler maps several groups that write the same register cell onto one physical register, so writes never collide.

Parameters:
- width, 32, data width of the register and of each request payload
- reset_val, 0, value loaded into the register on reset
- N, 4, number of requesters (N >= 2); grant index width is clog2(N)

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- req_valid  input  N  bit i high: requester i wants to write
- req_data  input  N*width  requester i's payload in bits [i*width +: width]
- req_ready  output  N  one-hot, one-cycle pulse: requester i's write committed this cycle
- out  output  width  current register contents
- busy  output  1  high while a granted write is in flight (BUSY state)
- grant  output  clog2(N)  index of the current or most recent winner

Behaviour:
- Reset: takes priority over every other input in the same cycle. Values after the edge:
  - register = reset_val
  - state = IDLE
  - rr_ptr = 0
  - grant = 0
  - req_ready = 0, busy = 0
- Reset mid-BUSY aborts the write: no commit, no ready pulse.
- FSM, two states:
  - IDLE:
    - No req_valid bit set: stay in IDLE, all outputs hold.
    - Otherwise, the winner is the first set bit of req_valid scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N.
    - On the edge: latch the winner index into grant and its req_data slice into data_q; go to BUSY.
  - BUSY:
    - busy = 1.
    - req_ready[grant] = 1 combinationally for this one cycle; all other bits are 0.
    - On the edge: register <= data_q; rr_ptr <= (grant+1) mod N; go to IDLE.
    - req_valid is ignored in BUSY; no new arbitration happens in this state.
- Timing:
  - Latency from grant edge to the new value on out: 1 cycle, i.e. out updates on the edge that ends BUSY.
  - Maximum throughput is one write per 2 cycles.
  - req_ready is asserted in the cycle before out shows the new value.
- Handshake rules:
  - A requester holds req_valid and req_data until it sees req_ready.
  - It may drop req_valid in the cycle after req_ready; if it keeps valid high, it is treated as a new request.
  - Data is sampled once, at the grant edge. Changes to req_data or deassertion of req_valid after grant do not affect the committed value; the commit still occurs.
- Fairness:
  - rr_ptr advances past each winner, so any continuously asserted requester is served within N grants.
  - Bits below rr_ptr are reached only by wrap-around.
- Datapath:
  - out is always driven from the register; there is no combinational bypass from req_data to out.
  - grant holds its last value in IDLE.
  - Widths are exact; no arithmetic on data.
- Pointer wrap: when grant = N-1, rr_ptr returns to 0.
- Simultaneous events:
  - A request arriving in the same cycle a ready pulse is issued is considered at the next IDLE cycle.
  - All requesters asserting at once are served in order rr_ptr, rr_ptr+1, ...

Test Plan (N=4, width=8, reset_val=8'h5A unless stated):
- Reset: hold reset 2 cycles with random req_valid -> out=8'h5A, req_ready=0, busy=0, grant=0 throughout; no commit.
- Single requester: req_valid=4'b0100, data2=8'h33 -> grant edge: grant=2, busy=1, req_ready=4'b0100 for exactly 1 cycle; next edge: out=8'h33, rr_ptr=3, busy=0.
- All four requesting continuously, data i=8'h10+i, from rr_ptr=0:
  - Grants 0,1,2,3,0 on successive 2-cycle slots.
  - out sequence 8'h10, 8'h11, 8'h12, 8'h13, 8'h10.
  - Exactly one req_ready bit high per slot.
- Wrap/skip: after a grant to 3 (rr_ptr=0), req_valid=4'b1010 -> winner 1, then 3; with req_valid=4'b0001 only, winner 0.
- Data change after grant: requester 1 valid with 8'hAA, switches to 8'hBB and drops valid during BUSY -> out=8'hAA, req_ready[1] pulses once.
- Reset during BUSY: grant requester 0 with 8'h77, assert reset in the BUSY cycle -> out=8'h5A, no req_ready pulse, state IDLE, rr_ptr=0.
